// File: rtl/mem_word_bridge.sv
// Word-to-byte bridge: splits a 32-bit load/store into four big-endian byte
// beats on a byte-wide single-port RAM and returns one response per request.
module mem_word_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_be,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_read,
    output logic                  ram_write,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [1:0] {IDLE, XFER, ERR, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              beat_reg, beat_next;
    logic [ADDR_WIDTH-3:0]   base_reg, base_next;
    logic                    write_reg, write_next;
    logic [31:0]             wdata_reg, wdata_next;
    logic [3:0]              be_reg, be_next;
    logic [31:0]             rdata_reg, rdata_next;
    logic                    err_reg, err_next;
    logic [ADDR_WIDTH-1:0]   ram_address_reg, ram_address_next;
    logic                    ram_read_reg, ram_read_next;
    logic                    ram_write_reg, ram_write_next;
    logic [DATA_WIDTH-1:0]   wbyte_reg, wbyte_next;
    logic [1:0]              nbeat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            beat_reg        <= '0;
            base_reg        <= '0;
            write_reg       <= 1'b0;
            wdata_reg       <= '0;
            be_reg          <= '0;
            rdata_reg       <= '0;
            err_reg         <= 1'b0;
            ram_address_reg <= '0;
            ram_read_reg    <= 1'b0;
            ram_write_reg   <= 1'b0;
            wbyte_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            beat_reg        <= beat_next;
            base_reg        <= base_next;
            write_reg       <= write_next;
            wdata_reg       <= wdata_next;
            be_reg          <= be_next;
            rdata_reg       <= rdata_next;
            err_reg         <= err_next;
            ram_address_reg <= ram_address_next;
            ram_read_reg    <= ram_read_next;
            ram_write_reg   <= ram_write_next;
            wbyte_reg       <= wbyte_next;
        end
    end

    // Byte lane k sits at bit offset 8*(3-k); for a 2-bit k, 3-k is simply ~k.
    assign nbeat = beat_reg + 2'd1;

    always_comb begin
        state_next       = state_reg;
        beat_next        = beat_reg;
        base_next        = base_reg;
        write_next       = write_reg;
        wdata_next       = wdata_reg;
        be_next          = be_reg;
        rdata_next       = rdata_reg;
        err_next         = err_reg;
        ram_address_next = ram_address_reg;
        ram_read_next    = 1'b0;
        ram_write_next   = 1'b0;
        wbyte_next       = wbyte_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    rdata_next = '0;
                    if (req_addr[1:0] != 2'b00) begin
                        err_next   = 1'b1;
                        state_next = ERR;
                    end else begin
                        err_next         = 1'b0;
                        base_next        = req_addr[ADDR_WIDTH-1:2];
                        write_next       = req_write;
                        wdata_next       = req_wdata;
                        be_next          = req_be;
                        beat_next        = 2'd0;
                        ram_address_next = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        ram_read_next    = ~req_write;
                        ram_write_next   = req_write & req_be[3];
                        wbyte_next       = req_wdata[31 -: DATA_WIDTH];
                        state_next       = XFER;
                    end
                end
            end
            XFER: begin
                if (!write_reg) begin
                    rdata_next[{~beat_reg, 3'b000} +: DATA_WIDTH] = ram_data;
                end
                if (beat_reg == 2'd3) begin
                    state_next = RESP;
                end else begin
                    beat_next        = nbeat;
                    ram_address_next = {base_reg, nbeat};
                    ram_read_next    = ~write_reg;
                    ram_write_next   = write_reg & be_reg[~nbeat];
                    wbyte_next       = wdata_reg[{~nbeat, 3'b000} +: DATA_WIDTH];
                end
            end
            ERR:     state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready   = (state_reg == IDLE);
    assign resp_valid  = (state_reg == RESP);
    assign resp_err    = resp_valid & err_reg;
    assign resp_rdata  = (resp_valid && !err_reg && !write_reg) ? rdata_reg : 32'h0;
    assign ram_address = ram_address_reg;
    assign ram_read    = ram_read_reg;
    assign ram_write   = ram_write_reg;
    assign ram_data    = ram_write_reg ? wbyte_reg : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_word_bridge.sv
// Directed bench for mem_word_bridge: stimulus pushes expected responses and
// RAM writes into queues; a negedge monitor pops and compares them.
module tb_mem_word_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  ram_address;
    logic        ram_read;
    logic        ram_write;
    wire  [7:0]  ram_data;

    logic [7:0]  mem [256];
    logic        tb_drv_en = 1'b0;
    logic [7:0]  tb_drv_val = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {logic [31:0] rdata; logic err; int at;} resp_t;
    typedef struct {logic [7:0] addr; logic [7:0] data;} wr_t;
    resp_t rq[$];
    wr_t   wq[$];
    resp_t re;
    wr_t   we;

    mem_word_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clock(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
        .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    // Byte RAM model: combinational read, posedge write
    assign ram_data = ram_read ? mem[ram_address] : 8'bz;
    assign ram_data = tb_drv_en ? tb_drv_val : 8'bz;
    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_data;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_exclusive", {31'b0, ram_read & ram_write}, 32'h0);
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    re = rq.pop_front();
                    check("resp_err", {31'b0, resp_err}, {31'b0, re.err});
                    check("resp_rdata", resp_rdata, re.rdata);
                    check("resp_cycle", cyc, re.at);
                    $display("resp: err=%0d rdata=%h cycle=%0d", resp_err, resp_rdata, cyc);
                end
            end
            if (ram_write) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got write @%h expected none", ram_address);
                end else begin
                    we = wq.pop_front();
                    check("wr_addr", {24'b0, ram_address}, {24'b0, we.addr});
                    check("wr_data", {24'b0, ram_data}, {24'b0, we.data});
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                         input bit want_resp, input int nbeats, output int t_acc);
        int n;
        resp_t r;
        wr_t w;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 for 50 cycles expected 1");
        end
        t_acc = cyc + 1;
        if (want_resp) begin
            r.rdata = exp_rd;
            r.err   = exp_err;
            r.at    = t_acc + (exp_err ? 1 : 4);
            rq.push_back(r);
        end
        if (wr && !exp_err) begin
            for (int k = 0; k < nbeats; k++) begin
                if (be[3-k]) begin
                    w.addr = a + 8'(k);
                    w.data = wd[31-8*k -: 8];
                    wq.push_back(w);
                end
            end
        end
        $display("req: %s addr=%h wdata=%h be=%b accepted cycle %0d",
                 wr ? "store" : "load", a, wd, be, t_acc);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'h0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        check({tag, "_resp_err"}, {31'b0, resp_err}, 32'h0);
        check({tag, "_ram_address"}, {24'b0, ram_address}, 32'h0);
        check({tag, "_ram_read"}, {31'b0, ram_read}, 32'h0);
        check({tag, "_ram_write"}, {31'b0, ram_write}, 32'h0);
        tb_drv_val = 8'h5A;
        tb_drv_en  = 1'b1;
        #1;
        check({tag, "_bus_released"}, {24'b0, ram_data}, 32'h5A);
        tb_drv_en = 1'b0;
    endtask

    initial begin
        int t, t2, n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        #12;
        reset_checks("por");
        @(negedge clk) rst = 1'b0;
        #1 check("por_req_ready", {31'b0, req_ready}, 32'h1);

        // asynchronous pulse while idle
        @(negedge clk);
        #2 rst = 1'b1;
        #1 reset_checks("idle_rst");
        @(negedge clk) rst = 1'b0;
        #1 check("idle_rst_req_ready", {31'b0, req_ready}, 32'h1);

        issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1, 4, t);
        issue(1'b0, 8'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, 4, t);
        issue(1'b1, 8'h10, 32'h11223344, 4'b0101, 32'h0, 1'b0, 1'b1, 4, t);
        issue(1'b0, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1, 4, t);
        issue(1'b0, 8'h40, 32'h0, 4'h0, 32'h40414243, 1'b0, 1'b1, 4, t);

        // misaligned load: error response one cycle after accept, no strobes
        issue(1'b0, 8'h11, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 4, t);
        @(negedge clk);
        check("mis_no_read", {31'b0, ram_read}, 32'h0);
        check("mis_no_write", {31'b0, ram_write}, 32'h0);

        // second request held while the first is busy
        issue(1'b0, 8'h10, 32'h0, 4'h0, 32'hDE22BE44, 1'b0, 1'b1, 4, t);
        issue(1'b1, 8'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1, 4, t2);
        check("accept_gap", t2 - t, 32'd6);
        issue(1'b0, 8'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1, 4, t);
        issue(1'b1, 8'h22, 32'h12345678, 4'hF, 32'h0, 1'b1, 1'b1, 4, t2);
        check("err_accept_gap", t2 - t, 32'd6);

        // reset during store beat 2: only beats 0 and 1 land
        issue(1'b1, 8'h10, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0, 1'b0, 2, t);
        n = 0;
        while (cyc < t + 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1 reset_checks("xfer_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("xfer_rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("mem_12_kept", {24'b0, mem[8'h12]}, 32'hBE);
        issue(1'b0, 8'h10, 32'h0, 4'h0, 32'hAABBBE44, 1'b0, 1'b1, 4, t);

        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("resp_queue_drained", rq.size(), 32'h0);
        check("write_queue_drained", wq.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
